lane_serializer_8_1: RTL and testbench

LANE_SERIALIZER_8_1 -- requirements
Module: lane_serializer_8_1

---
 rtl/lane_serializer_8_1.sv | 129 ++++++++++++
 tb/tb_lane_serializer_8_1.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lane_serializer_8_1.sv
// Eight-lane to one-lane serializer: captures a frame of eight samples and
// emits the enabled lanes in ascending index order over a valid/ready port.
module lane_serializer_8_1 #(
  parameter int unsigned WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [8*WIDTH-1:0]   data_in,
  input  logic [7:0]           lane_en,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned LANES = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [8*WIDTH-1:0]   data_q, data_d;
  logic [7:0]           en_q, en_d;
  logic [WIDTH-1:0]     out_data_d;
  logic [2:0]           out_sel_d;
  logic                 out_valid_d;
  logic                 frame_done_d;
  logic                 overrun_d;

  logic [WIDTH-1:0]     lane_in [LANES];
  logic [WIDTH-1:0]     lane_q  [LANES];
  logic [7:0]           higher_en;
  logic [2:0]           first_idx;
  logic [2:0]           next_idx;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_in[k] = data_in[k*WIDTH +: WIDTH];
    assign lane_q[k]  = data_q[k*WIDTH +: WIDTH];
  end

  // Index of the lowest set bit; zero when none are set.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Enabled lanes strictly above the one currently presented.
  assign higher_en = en_q & ~((8'd2 << out_sel) - 8'd1);
  assign first_idx = lowest_idx(lane_en);
  assign next_idx  = lowest_idx(higher_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      en_q       <= '0;
      out_data   <= '0;
      out_sel    <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      en_q       <= en_d;
      out_data   <= out_data_d;
      out_sel    <= out_sel_d;
      out_valid  <= out_valid_d;
      busy       <= (state_d == SEND);
      frame_done <= frame_done_d;
      overrun    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    en_d         = en_q;
    out_data_d   = out_data;
    out_sel_d    = out_sel;
    out_valid_d  = out_valid;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          data_d = data_in;
          en_d   = lane_en;
          if (lane_en != 8'd0) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            out_sel_d   = first_idx;
            out_data_d  = lane_in[first_idx];
          end else begin
            frame_done_d = 1'b1;
          end
        end
      end
      SEND: begin
        overrun_d = load;
        if (out_valid && out_ready) begin
          // Advance without a bubble, or close the frame after the top lane.
          if (higher_en != 8'd0) begin
            out_sel_d  = next_idx;
            out_data_d = lane_q[next_idx];
          end else begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lane_serializer_8_1.sv
// Directed bench for lane_serializer_8_1: per-cycle vector table plus a
// hand-written mid-frame reset sequence.
module tb_lane_serializer_8_1;

  localparam int unsigned WIDTH = 24;

  logic               clk;
  logic               rst;
  logic               load;
  logic [8*WIDTH-1:0] data_in;
  logic [7:0]         lane_en;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               frame_done;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  lane_serializer_8_1 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .lane_en    (lane_en),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             load;
    logic [7:0]       en;
    logic [WIDTH-1:0] base;
    logic             rdy;
    logic             e_valid;
    logic [2:0]       e_sel;
    logic [WIDTH-1:0] e_data;
    logic             e_busy;
    logic             e_done;
    logic             e_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ld, input logic [7:0] en,
                     input logic [WIDTH-1:0] base, input logic rdy,
                     input logic ev, input logic [2:0] es, input logic [WIDTH-1:0] ed,
                     input logic eb, input logic edn, input logic eo);
    vec_t v;
    v.rst = r; v.load = ld; v.en = en; v.base = base; v.rdy = rdy;
    v.e_valid = ev; v.e_sel = es; v.e_data = ed; v.e_busy = eb;
    v.e_done = edn; v.e_ovr = eo;
    vecs.push_back(v);
  endtask

  function automatic logic [8*WIDTH-1:0] make_data(input logic [WIDTH-1:0] base);
    logic [8*WIDTH-1:0] d;
    for (int k = 0; k < 8; k++) d[k*WIDTH +: WIDTH] = base + WIDTH'(k);
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [2:0] es,
                               input logic [WIDTH-1:0] ed, input logic eb,
                               input logic edn, input logic eo);
    check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    if (ev) check({tag, " out_sel"}, 32'(out_sel), 32'(es));
    check({tag, " out_data"}, 32'(out_data), 32'(ed));
    check({tag, " busy"}, 32'(busy), 32'(eb));
    check({tag, " frame_done"}, 32'(frame_done), 32'(edn));
    check({tag, " overrun"}, 32'(overrun), 32'(eo));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lane_en = 8'h00; data_in = '0; out_ready = 1'b1;
    #1;
    check_outputs("reset0", 1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b0);

    //   rst ld  en     base       rdy  v  sel   data       busy done ovr
    add(1, 0, 8'h00, 24'h000000, 1, 0, 3'd0, 24'h000000, 0, 0, 0);
    add(0, 0, 8'h00, 24'h000000, 1, 0, 3'd0, 24'h000000, 0, 0, 0);
    // Full frame, all lanes
    add(0, 1, 8'hFF, 24'h100000, 1, 1, 3'd0, 24'h100000, 1, 0, 0);
    for (int k = 1; k < 8; k++)
      add(0, 0, 8'hFF, 24'h100000, 1, 1, 3'(k), 24'h100000 + 24'(k), 1, 0, 0);
    add(0, 0, 8'hFF, 24'h100000, 1, 0, 3'd7, 24'h100007, 0, 1, 0);
    add(0, 0, 8'hFF, 24'h100000, 1, 0, 3'd7, 24'h100007, 0, 0, 0);
    // Sparse mask; inputs change after capture and must not matter
    add(0, 1, 8'hA4, 24'h200000, 1, 1, 3'd2, 24'h200002, 1, 0, 0);
    add(0, 0, 8'hFF, 24'h300000, 1, 1, 3'd5, 24'h200005, 1, 0, 0);
    add(0, 0, 8'h01, 24'h310000, 1, 1, 3'd7, 24'h200007, 1, 0, 0);
    add(0, 0, 8'h00, 24'h320000, 1, 0, 3'd7, 24'h200007, 0, 1, 0);
    add(0, 0, 8'h00, 24'h320000, 1, 0, 3'd7, 24'h200007, 0, 0, 0);
    // Backpressure on lane 0
    add(0, 1, 8'h03, 24'h400000, 0, 1, 3'd0, 24'h400000, 1, 0, 0);
    add(0, 0, 8'h03, 24'h400000, 0, 1, 3'd0, 24'h400000, 1, 0, 0);
    add(0, 0, 8'h03, 24'h400000, 0, 1, 3'd0, 24'h400000, 1, 0, 0);
    add(0, 0, 8'h03, 24'h400000, 0, 1, 3'd0, 24'h400000, 1, 0, 0);
    add(0, 0, 8'h03, 24'h400000, 1, 1, 3'd1, 24'h400001, 1, 0, 0);
    add(0, 0, 8'h03, 24'h400000, 1, 0, 3'd1, 24'h400001, 0, 1, 0);
    add(0, 0, 8'h03, 24'h400000, 1, 0, 3'd1, 24'h400001, 0, 0, 0);
    // Load while busy is rejected; then empty-mask load
    add(0, 1, 8'h06, 24'h500000, 1, 1, 3'd1, 24'h500001, 1, 0, 0);
    add(0, 1, 8'hFF, 24'h600000, 1, 1, 3'd2, 24'h500002, 1, 0, 1);
    add(0, 0, 8'hFF, 24'h600000, 1, 0, 3'd2, 24'h500002, 0, 1, 0);
    add(0, 1, 8'h00, 24'h610000, 1, 0, 3'd2, 24'h500002, 0, 1, 0);
    add(0, 0, 8'h00, 24'h610000, 1, 0, 3'd2, 24'h500002, 0, 0, 0);
    // Load held high, single lane: back-to-back frames
    add(0, 1, 8'h01, 24'h700000, 1, 1, 3'd0, 24'h700000, 1, 0, 0);
    add(0, 1, 8'h01, 24'h700000, 1, 0, 3'd0, 24'h700000, 0, 1, 1);
    add(0, 1, 8'h01, 24'h700000, 1, 1, 3'd0, 24'h700000, 1, 0, 0);
    add(0, 1, 8'h01, 24'h700000, 1, 0, 3'd0, 24'h700000, 0, 1, 1);
    add(0, 1, 8'h01, 24'h710000, 1, 1, 3'd0, 24'h710000, 1, 0, 0);
    add(0, 0, 8'h01, 24'h710000, 1, 0, 3'd0, 24'h710000, 0, 1, 0);
    add(0, 0, 8'h01, 24'h710000, 1, 0, 3'd0, 24'h710000, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; load = vecs[i].load; lane_en = vecs[i].en;
      data_in = make_data(vecs[i].base); out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_sel,
                    vecs[i].e_data, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ovr);
    end

    // Reset mid-frame at lane 3 abandons the frame
    @(negedge clk);
    load = 1'b1; lane_en = 8'hFF; data_in = make_data(24'h800000); out_ready = 1'b1;
    @(posedge clk); #1;
    check_outputs("rst_seq start", 1'b1, 3'd0, 24'h800000, 1'b1, 1'b0, 1'b0);
    @(negedge clk); load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("rst_seq lane3", 1'b1, 3'd3, 24'h800003, 1'b1, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_seq async out_sel", 32'(out_sel), 32'd0);
    check_outputs("rst_seq async", 1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_outputs($sformatf("rst_seq quiet%0d", c), 1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    load = 1'b1; lane_en = 8'h01; data_in = make_data(24'h900000);
    @(posedge clk); #1;
    check_outputs("rst_seq reload", 1'b1, 3'd0, 24'h900000, 1'b1, 1'b0, 1'b0);
    @(negedge clk); load = 1'b0;
    @(posedge clk); #1;
    check_outputs("rst_seq done", 1'b0, 3'd0, 24'h900000, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
